// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for the multicycle mini MIPS datapath with a byte-wide memory.
// It runs the four byte fetch cycles, the decode cycle and the execute and
// writeback steps for each opcode. It drives every datapath enable and every
// mux select as a Moore function of the current state.
//
// Optional feature macro: MIPS_CTRL_ADDI_EN
//   When this macro is defined, opcode 001000 (ADDI) is legal and uses the
//   path DECODE -> MEMADR -> ADDIWR -> FETCH1.
//   When it is undefined, ADDI is an illegal opcode and ADDIWR is never reached.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low (0 = in reset)
//   op         in   [5:0] instr[31:26] from the instruction register
//   zero       in   ALU zero flag, used only in BEQEX
//   memread    out  memory read strobe
//   memwrite   out  memory write strobe
//   irwrite    out  [3:0] one-hot instruction register byte enable (bit0 = instr[7:0])
//   iord       out  address mux: 0 = PC, 1 = ALUOut
//   alusrca    out  ALU A mux: 0 = PC, 1 = regA
//   alusrcb    out  [1:0] ALU B mux: 00 regB, 01 const 1, 10 imm, 11 imm<<2
//   aluop      out  [1:0] 00 add, 01 sub, 10 funct-decoded
//   pcsource   out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   pcen       out  PC load enable, pcwrite | (pcwritecond & zero)
//   regwrite   out  register file write
//   regdst     out  0 = rt, 1 = rd
//   memtoreg   out  0 = ALUOut, 1 = MDR
//   illegal_op out  one-cycle pulse in DECODE for an unsupported opcode
//   dbg_state  out  [STATE_W-1:0] current state encoding
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic [3:0]         irwrite,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               pcen,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH1  = STATE_W'(0),
    S_FETCH2  = STATE_W'(1),
    S_FETCH3  = STATE_W'(2),
    S_FETCH4  = STATE_W'(3),
    S_DECODE  = STATE_W'(4),
    S_MEMADR  = STATE_W'(5),
    S_LBRD    = STATE_W'(6),
    S_LBWR    = STATE_W'(7),
    S_SBWR    = STATE_W'(8),
    S_RTYPEEX = STATE_W'(9),
    S_RTYPEWR = STATE_W'(10),
    S_BEQEX   = STATE_W'(11),
    S_JEX     = STATE_W'(12),
    S_ADDIWR  = STATE_W'(13)
  } state_e;

  state_e state_q, state_d;
  logic   pcwrite, pcwritecond;

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the value from before the clock edge and simulation matches the hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default value before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 4'b0000;
    iord        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    illegal_op  = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;

    // Outputs are also gated by reset, not only by the state register. This
    // forces every strobe low as soon as reset is asserted, even in the middle
    // of an instruction and before any clock edge.
    if (reset) begin
      case (state_q)
        S_FETCH1: begin
          memread = 1'b1; irwrite = 4'b0001; alusrcb = 2'b01; pcwrite = 1'b1;
          state_d = S_FETCH2;
        end
        S_FETCH2: begin
          memread = 1'b1; irwrite = 4'b0010; alusrcb = 2'b01; pcwrite = 1'b1;
          state_d = S_FETCH3;
        end
        S_FETCH3: begin
          memread = 1'b1; irwrite = 4'b0100; alusrcb = 2'b01; pcwrite = 1'b1;
          state_d = S_FETCH4;
        end
        S_FETCH4: begin
          memread = 1'b1; irwrite = 4'b1000; alusrcb = 2'b01; pcwrite = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_LB, OP_SB: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTYPEEX;
            OP_BEQ:       state_d = S_BEQEX;
            OP_J:         state_d = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI:      state_d = S_MEMADR;
`endif
            default: begin
              // The PC was already advanced during fetch, so restarting the
              // fetch simply skips the bad instruction.
              illegal_op = 1'b1;
              state_d    = S_FETCH1;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1; alusrcb = 2'b10;
          case (op)
            OP_LB:   state_d = S_LBRD;
            OP_SB:   state_d = S_SBWR;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI: state_d = S_ADDIWR;
`endif
            default: state_d = S_FETCH1;
          endcase
        end
        S_LBRD: begin
          memread = 1'b1; iord = 1'b1;
          state_d = S_LBWR;
        end
        S_LBWR: begin
          regwrite = 1'b1; memtoreg = 1'b1;
          state_d  = S_FETCH1;
        end
        S_SBWR: begin
          memwrite = 1'b1; iord = 1'b1;
          state_d  = S_FETCH1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1; aluop = 2'b10;
          state_d = S_RTYPEWR;
        end
        S_RTYPEWR: begin
          regwrite = 1'b1; regdst = 1'b1;
          state_d  = S_FETCH1;
        end
        S_BEQEX: begin
          alusrca = 1'b1; aluop = 2'b01; pcsource = 2'b01; pcwritecond = 1'b1;
          state_d = S_FETCH1;
        end
        S_JEX: begin
          pcwrite = 1'b1; pcsource = 2'b10;
          state_d = S_FETCH1;
        end
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDIWR: begin
          regwrite = 1'b1;
          state_d  = S_FETCH1;
        end
`endif
        default: state_d = S_FETCH1;
      endcase
    end

    pcen      = pcwrite | (pcwritecond & zero);
    dbg_state = reset ? state_q : '0;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Self-checking bench for mips_multicycle_ctrl.
// For each instruction, the bench takes the expected state walk from a
// per-opcode path table. Each cycle it pushes the expected output vector for
// that state into a scoreboard queue. At the following falling edge it pops the
// entry and compares it with the DUT outputs.
// Outside the states that sample them, op and zero are driven with random
// values.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op    = 6'd0;
  logic       zero  = 1'b0;
  logic       memread, memwrite, iord, alusrca, pcen;
  logic       regwrite, regdst, memtoreg, illegal_op;
  logic [3:0] irwrite, dbg_state;
  logic [1:0] alusrcb, aluop, pcsource;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw;
    logic [3:0] irw;
    logic       iord, asa;
    logic [1:0] asb, aop, psrc;
    logic       pcen, rw, rd, m2r, ill;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsource   (pcsource),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .illegal_op (illegal_op),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.st = dbg_state;  o.mr = memread;   o.mw = memwrite;  o.irw = irwrite;
    o.iord = iord;     o.asa = alusrca;  o.asb = alusrcb;  o.aop = aluop;
    o.psrc = pcsource; o.pcen = pcen;    o.rw = regwrite;  o.rd = regdst;
    o.m2r = memtoreg;  o.ill = illegal_op;
    return o;
  endfunction

  // Expected Moore outputs for one state. In BEQEX, z is the zero flag.
  function automatic exp_t exp_of(input int st, input logic z, input logic ill);
    exp_t e = '0;
    e.st = 4'(st);
    case (st)
      0, 1, 2, 3: begin e.mr = 1; e.irw = 4'b0001 << st; e.asb = 2'b01; e.pcen = 1; end
      4:  begin e.asb = 2'b11; e.ill = ill; end
      5:  begin e.asa = 1; e.asb = 2'b10; end
      6:  begin e.mr = 1; e.iord = 1; end
      7:  begin e.rw = 1; e.m2r = 1; end
      8:  begin e.mw = 1; e.iord = 1; end
      9:  begin e.asa = 1; e.aop = 2'b10; end
      10: begin e.rw = 1; e.rd = 1; end
      11: begin e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.pcen = z; end
      12: begin e.pcen = 1; e.psrc = 2'b10; end
      13: begin e.rw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Runs at most max_cyc cycles of one instruction. The task is entered just
  // after a rising edge, with FETCH1 current. It returns just after the rising
  // edge that ends the instruction. If the run is cut short, it returns at the
  // falling edge of the last compared cycle instead.
  task automatic run_instr(input string name, input logic [5:0] opc,
                           input logic zbeq, input int max_cyc);
    int   path[$];
    logic ill = 1'b0;
    case (opc)
      6'b100000: path = {0, 1, 2, 3, 4, 5, 6, 7};
      6'b101000: path = {0, 1, 2, 3, 4, 5, 8};
      6'b000000: path = {0, 1, 2, 3, 4, 9, 10};
      6'b000100: path = {0, 1, 2, 3, 4, 11};
      6'b000010: path = {0, 1, 2, 3, 4, 12};
`ifdef MIPS_CTRL_ADDI_EN
      6'b001000: path = {0, 1, 2, 3, 4, 5, 13};
`endif
      default: begin path = {0, 1, 2, 3, 4}; ill = 1'b1; end
    endcase
    for (int i = 0; i < path.size() && i < max_cyc; i++) begin
      int   st = path[i];
      exp_t e;
      op   = (st == 4 || st == 5) ? opc : 6'($urandom_range(0, 63));
      zero = (st == 11) ? zbeq : 1'($urandom_range(0, 1));
      sb_q.push_back(exp_of(st, zbeq, ill && st == 4));
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("%s cyc%0d", name, i), 32'(observed()), 32'(e));
      if (i + 1 < max_cyc) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    // While reset is held, every output must stay 0, whatever op and zero do.
    for (int i = 0; i < 2; i++) begin
      op   = 6'($urandom_range(0, 63));
      zero = 1'b1;
      @(negedge clk);
      check("reset outputs", 32'(observed()), 32'(0));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("release fetch1", 32'(observed()), 32'(exp_of(0, 1'b0, 1'b0)));

    run_instr("LB",      6'b100000, 1'b0, 100);
    run_instr("SB",      6'b101000, 1'b0, 100);
    run_instr("RTYPE",   6'b000000, 1'b0, 100);
    run_instr("BEQ z1",  6'b000100, 1'b1, 100);
    run_instr("BEQ z0",  6'b000100, 1'b0, 100);
    run_instr("J",       6'b000010, 1'b0, 100);
    run_instr("ILLEGAL", 6'b111111, 1'b0, 100);
    run_instr("ADDI",    6'b001000, 1'b0, 100);
    run_instr("RTYPE2",  6'b000000, 1'b0, 100);

    // Abort an LB in LBRD. The outputs must clear right away, with no clock
    // edge needed.
    run_instr("LB abort", 6'b100000, 1'b0, 7);
    #1 reset = 1'b0;
    #1 check("async reset mid-LB", 32'(observed()), 32'(0));
    @(posedge clk);
    #1 check("reset held", 32'(observed()), 32'(0));
    reset = 1'b1;
    #1 check("re-release fetch1", 32'(observed()), 32'(exp_of(0, 1'b0, 1'b0)));
    run_instr("LB after reset", 6'b100000, 1'b0, 100);
    run_instr("J after reset",  6'b000010, 1'b0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
